clk_div_prog: RTL



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clk_div_core.sv | 52 +++++
 rtl/clk_div_prog.sv | 79 +++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int DEF_CNT_W = 28;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_TICK   = 1'b1;

  // A divisor of 0 has no meaning, so it is treated as 1 (event every cycle).
  function automatic logic [63:0] coerce_div(input logic [63:0] d);
    return (d == 64'd0) ? 64'd1 : d;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// div_load is a one-cycle request with no ready: it is always accepted on the edge where it is high.
interface clk_div_prog_if #(
  parameter int CNT_W = 28
);
  logic             en;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             mode_in;
  logic             clk_out;
  logic             tick;
  logic             pending;
  logic [CNT_W-1:0] div_active;

  modport master (
    output en, div_load, div_value, mode_in,
    input  clk_out, tick, pending, div_active
  );

  modport slave (
    input  en, div_load, div_value, mode_in,
    output clk_out, tick, pending, div_active
  );
endinterface

// File: rtl/clk_div_core.sv
// Counter, terminal detect and clk_out/tick output registers.
// mode_next is the mode that will be in force after this edge.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_active,
  input  logic             mode,
  input  logic             mode_next,
  output logic             term,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt;

  assign nxt  = cnt + CNT_W'(1);
  assign term = en && (nxt == div_active);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (clr) begin
      // Idle reload: restart the count cleanly under the new settings.
      cnt  <= '0;
      tick <= 1'b0;
      if (mode_next == MODE_TICK) clk_out <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      // The event acts in the old mode, but a switch to square suppresses the strobe.
      tick <= (mode == MODE_TICK) && (mode_next == MODE_TICK);
      if (mode_next == MODE_TICK)
        clk_out <= 1'b0;
      else if (mode == MODE_SQUARE)
        clk_out <= ~clk_out;
    end else begin
      cnt  <= nxt;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: shadow/pending reload control around clk_div_core.
// New settings take effect only at a terminal event (or at once while disabled).
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV  = 50000000,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  clk_div_prog_if.slave  bus
);

  logic             term;
  logic             load_now;
  logic             apply_shadow;
  logic [CNT_W-1:0] div_req;
  logic [CNT_W-1:0] div_active;
  logic [CNT_W-1:0] shadow_div;
  logic             mode;
  logic             mode_next;
  logic             shadow_mode;
  logic             pending;

  assign div_req      = CNT_W'(coerce_div(64'(bus.div_value)));
  // A load while idle or on the wrap edge skips the shadow entirely.
  assign load_now     = bus.div_load && (!bus.en || term);
  assign apply_shadow = term && pending;

  always_comb begin
    mode_next = mode;
    if (load_now)
      mode_next = bus.mode_in;
    else if (apply_shadow)
      mode_next = shadow_mode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_active  <= CNT_W'(DEFAULT_DIV);
      mode        <= DEFAULT_MODE;
      shadow_div  <= '0;
      shadow_mode <= 1'b0;
      pending     <= 1'b0;
    end else if (load_now) begin
      div_active <= div_req;
      mode       <= bus.mode_in;
      pending    <= 1'b0;
    end else if (apply_shadow) begin
      div_active <= shadow_div;
      mode       <= shadow_mode;
      pending    <= 1'b0;
    end else if (bus.div_load) begin
      shadow_div  <= div_req;
      shadow_mode <= bus.mode_in;
      pending     <= 1'b1;
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .en         (bus.en),
    .clr        (bus.div_load && !bus.en),
    .div_active (div_active),
    .mode       (mode),
    .mode_next  (mode_next),
    .term       (term),
    .clk_out    (bus.clk_out),
    .tick       (bus.tick)
  );

  assign bus.pending    = pending;
  assign bus.div_active = div_active;

endmodule
